// File: rtl/usb_serial_in_ep.sv
// Bulk IN endpoint: buffers a device byte stream, slices it into packets of up
// to MAX_PKT bytes for the protocol engine, and closes a full-size burst with a ZLP.
module usb_serial_in_ep #(
  parameter int FIFO_DEPTH   = 64,
  parameter int MAX_PKT      = 32,
  parameter int IDLE_TIMEOUT = 4800
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       stall_i,
  output logic       in_ep_req,
  input  logic       in_ep_grant,
  input  logic       in_ep_data_free,
  output logic       in_ep_data_put,
  output logic [7:0] in_ep_data,
  output logic       in_ep_data_done,
  output logic       in_ep_stall,
  input  logic       in_ep_acked
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(MAX_PKT) + 1;
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   MAX_CNT_C = (AW + 1)'(MAX_PKT);
  localparam logic [PW-1:0] MAX_PKT_C = PW'(MAX_PKT);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(IDLE_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_DONE,
    S_WAIT_ACK
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [TW-1:0] idle_tmr;
  logic          zlp_pending;
  logic [PW-1:0] target, target_nxt, sent;
  logic          clr_sent, ack_seen, full_start;
  logic          stall_q;

  assign wr_ready    = count < DEPTH_C;
  assign push        = wr_valid & wr_ready;
  assign pop         = in_ep_data_put;
  // Head is forced to zero while empty so the byte lane idles at a known value.
  assign in_ep_data  = (count != '0) ? mem[rd_ptr] : 8'h00;
  assign in_ep_stall = stall_q;

  // FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Packet sequencing
  always_comb begin
    state_nxt       = state;
    target_nxt      = target;
    in_ep_req       = 1'b0;
    in_ep_data_put  = 1'b0;
    in_ep_data_done = 1'b0;
    clr_sent        = 1'b0;
    ack_seen        = 1'b0;
    full_start      = 1'b0;
    case (state)
      S_IDLE: begin
        if (count >= MAX_CNT_C) begin
          target_nxt = MAX_PKT_C;
          full_start = 1'b1;
          state_nxt  = S_REQ;
        end else if (idle_tmr == TIMEOUT_C && count != '0) begin
          target_nxt = PW'(count);
          state_nxt  = S_REQ;
        end else if (idle_tmr == TIMEOUT_C && zlp_pending) begin
          target_nxt = '0;
          state_nxt  = S_REQ;
        end
      end
      S_REQ: begin
        in_ep_req = 1'b1;
        if (in_ep_grant) begin
          clr_sent  = 1'b1;
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        in_ep_req      = 1'b1;
        in_ep_data_put = in_ep_grant & in_ep_data_free & (sent < target);
        if (!in_ep_data_put && sent == target) state_nxt = S_DONE;
      end
      S_DONE: begin
        in_ep_req       = 1'b1;
        in_ep_data_done = 1'b1;
        state_nxt       = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        in_ep_req = 1'b1;
        if (in_ep_acked) begin
          ack_seen  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      target      <= '0;
      sent        <= '0;
      zlp_pending <= 1'b0;
    end else begin
      state  <= state_nxt;
      target <= target_nxt;
      if (clr_sent)            sent <= '0;
      else if (in_ep_data_put) sent <= sent + 1'b1;
      // A full packet needs a trailing ZLP unless more data follows it.
      if (ack_seen)        zlp_pending <= (target == MAX_PKT_C);
      else if (full_start) zlp_pending <= 1'b0;
    end
  end

  // Idle flush timer, only runs while IDLE has something to flush
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_tmr <= '0;
    end else if (push || state != S_IDLE || state_nxt != S_IDLE) begin
      idle_tmr <= '0;
    end else if ((count != '0 || zlp_pending) && idle_tmr != TIMEOUT_C) begin
      idle_tmr <= idle_tmr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= 1'b0;
    else       stall_q <= stall_i;
  end

endmodule

// File: tb/tb_usb_serial_in_ep.sv
// Directed bench for usb_serial_in_ep: packetisation, idle flush, ZLP,
// back-pressure, FIFO full, mid-packet reset and stall passthrough.
module tb_usb_serial_in_ep;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       stall_i;
  logic       in_ep_req;
  logic       in_ep_grant;
  logic       in_ep_data_free;
  logic       in_ep_data_put;
  logic [7:0] in_ep_data;
  logic       in_ep_data_done;
  logic       in_ep_stall;
  logic       in_ep_acked;

  usb_serial_in_ep #(.FIFO_DEPTH(64), .MAX_PKT(32), .IDLE_TIMEOUT(4800)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .stall_i(stall_i), .in_ep_req(in_ep_req),
    .in_ep_grant(in_ep_grant), .in_ep_data_free(in_ep_data_free),
    .in_ep_data_put(in_ep_data_put), .in_ep_data(in_ep_data),
    .in_ep_data_done(in_ep_data_done), .in_ep_stall(in_ep_stall),
    .in_ep_acked(in_ep_acked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic stall;
    logic exp_stall;
  } vec_t;
  vec_t vecs[8];

  int tests = 0;
  int fails = 0;
  logic [7:0] cap[$];
  int done_cnt = 0;
  int bad_put = 0;

  always @(negedge clk) begin
    if (in_ep_data_put) begin
      cap.push_back(in_ep_data);
      if (!in_ep_data_free) bad_put++;
    end
    if (in_ep_data_done) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; stall_i = 1'b0;
    in_ep_grant = 1'b0; in_ep_data_free = 1'b0; in_ep_acked = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    cap.delete();
    done_cnt = 0;
    bad_put = 0;
  endtask

  task automatic push_seq(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      wr_data  = 8'(base + i);
      wr_valid = 1'b1;
    end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (in_ep_data_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_req(input int max, output int cyc);
    cyc = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (in_ep_req) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic send_ack();
    tick();
    in_ep_acked = 1'b1;
    tick();
    in_ep_acked = 1'b0;
  endtask

  function automatic int pkt_errs(input int base, input int n);
    int e = 0;
    for (int i = 0; i < n && i < cap.size(); i++)
      if (cap[i] !== 8'(base + i)) e++;
    return e;
  endfunction

  initial begin
    bit ok;
    int cyc;
    int acc;

    vecs[0] = '{1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0};

    reset = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; stall_i = 1'b0;
    in_ep_grant = 1'b0; in_ep_data_free = 1'b0; in_ep_acked = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_req", in_ep_req, 0);
    check("rst_put", in_ep_data_put, 0);
    check("rst_done", in_ep_data_done, 0);
    check("rst_stall", in_ep_stall, 0);
    check("rst_data", in_ep_data, 0);
    check("rst_wr_ready", wr_ready, 1);

    // 1: full packet, ack, then ZLP after idle timeout
    in_ep_grant = 1'b1; in_ep_data_free = 1'b1;
    push_seq(8'h00, 32);
    wait_done(200, ok);
    check("t1_done_seen", ok, 1);
    send_ack();
    @(negedge clk);
    check("t1_req_drop", in_ep_req, 0);
    check("t1_pkt_size", cap.size(), 32);
    check("t1_pkt_data", pkt_errs(8'h00, 32), 0);
    wait_req(6000, cyc);
    check("t1_zlp_delay_ok", (cyc >= 4795 && cyc <= 4805), 1);
    wait_done(50, ok);
    check("t1_zlp_done", ok, 1);
    tick();
    check("t1_zlp_no_puts", cap.size(), 32);
    check("t1_done_cnt", done_cnt, 2);
    send_ack();
    wait_req(4900, cyc);
    check("t1_no_second_zlp", cyc, -1);

    // 2: short packet flushed on idle timeout, no ZLP afterwards
    do_reset();
    in_ep_grant = 1'b1; in_ep_data_free = 1'b1;
    push_seq(8'hA1, 5);
    wait_req(6000, cyc);
    check("t2_flush_delay_ok", (cyc >= 4798 && cyc <= 4803), 1);
    wait_done(50, ok);
    check("t2_done_seen", ok, 1);
    check("t2_pkt_size", cap.size(), 5);
    check("t2_pkt_data", pkt_errs(8'hA1, 5), 0);
    send_ack();
    wait_req(4900, cyc);
    check("t2_no_zlp", cyc, -1);

    // 3: data_free toggling every 3 cycles
    do_reset();
    in_ep_grant = 1'b1;
    for (int c = 0; c < 240; c++) begin
      tick();
      in_ep_data_free = ((c / 3) % 2 == 0);
      if (c < 32) begin
        wr_valid = 1'b1;
        wr_data  = 8'(8'h80 + c);
      end else begin
        wr_valid = 1'b0;
      end
    end
    in_ep_data_free = 1'b1;
    check("t3_pkt_size", cap.size(), 32);
    check("t3_pkt_data", pkt_errs(8'h80, 32), 0);
    check("t3_put_without_free", bad_put, 0);
    check("t3_done_cnt", done_cnt, 1);
    send_ack();

    // 4: FIFO fills to 64 while grant is withheld
    do_reset();
    in_ep_data_free = 1'b1;
    acc = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      wr_data  = 8'(acc);
      wr_valid = 1'b1;
      if (wr_ready) acc++;
    end
    tick();
    wr_valid = 1'b0;
    check("t4_accepted", acc, 64);
    @(negedge clk);
    check("t4_wr_ready_full", wr_ready, 0);
    check("t4_req_held", in_ep_req, 1);
    check("t4_no_puts", cap.size(), 0);
    tick();
    in_ep_grant = 1'b1;
    wait_done(200, ok);
    check("t4_done1", ok, 1);
    send_ack();
    wait_done(200, ok);
    check("t4_done2", ok, 1);
    send_ack();
    check("t4_pkt_size", cap.size(), 64);
    check("t4_pkt_data", pkt_errs(0, 64), 0);
    check("t4_done_cnt", done_cnt, 2);

    // 5: reset in the middle of a packet
    do_reset();
    in_ep_grant = 1'b1; in_ep_data_free = 1'b1;
    push_seq(8'h00, 32);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cap.size() >= 10) break;
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t5_req_after_rst", in_ep_req, 0);
    check("t5_put_after_rst", in_ep_data_put, 0);
    check("t5_wr_ready_after_rst", wr_ready, 1);
    repeat (20) tick();
    check("t5_no_done", done_cnt, 0);
    cap.delete();
    push_seq(8'h40, 32);
    wait_done(200, ok);
    check("t5_done_seen", ok, 1);
    check("t5_pkt_size", cap.size(), 32);
    check("t5_pkt_data", pkt_errs(8'h40, 32), 0);
    send_ack();

    // 6: stall passthrough while a packet is in flight
    do_reset();
    in_ep_grant = 1'b1; in_ep_data_free = 1'b1;
    push_seq(8'hC0, 32);
    for (int r = 0; r < 8; r++) begin
      tick();
      stall_i = vecs[r].stall;
      @(negedge clk);
      check($sformatf("t6_stall_row%0d", r), in_ep_stall, vecs[r].exp_stall);
    end
    wait_done(200, ok);
    check("t6_done_seen", ok, 1);
    tick();
    check("t6_pkt_size", cap.size(), 32);
    check("t6_pkt_data", pkt_errs(8'hC0, 32), 0);
    check("t6_done_cnt", done_cnt, 1);
    send_ack();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
